// File: rtl/tlu_trig_seq.sv
// tlu_trig_seq: trigger sequencer ahead of the TLU transmitter. Issues
// a one-cycle TRIG with its TRIG_ID from an internal period timer or a
// synchronised EXT_TRIG edge, honours READY, and counts trig/skip/timeout.
// Ports: SYS_CLK, SYS_RST (async, high); START/STOP run control;
//   CONF_* run configuration; EXT_TRIG async trigger; READY/TIME_OUT
//   from the transmitter; TRIG/TRIG_ID to the transmitter; BUSY/DONE
//   status; TRIG_CNT/SKIP_CNT/TIMEOUT_CNT per-run counters.
module tlu_trig_seq #(
  parameter int ID_WIDTH     = 31,
  parameter int CNT_WIDTH    = 32,
  parameter int TO_CNT_WIDTH = 16
) (
  input  logic                    SYS_CLK,
  input  logic                    SYS_RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic                    CONF_EXT,
  input  logic                    CONF_SKIP,
  input  logic [31:0]             CONF_PERIOD,
  input  logic [CNT_WIDTH-1:0]    CONF_N_TRIG,
  input  logic                    EXT_TRIG,
  input  logic                    READY,
  input  logic                    TIME_OUT,
  output logic                    TRIG,
  output logic [ID_WIDTH-1:0]     TRIG_ID,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [CNT_WIDTH-1:0]    TRIG_CNT,
  output logic [CNT_WIDTH-1:0]    SKIP_CNT,
  output logic [TO_CNT_WIDTH-1:0] TIMEOUT_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [ID_WIDTH-1:0] ID_ONE =
    {{(ID_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TO_CNT_WIDTH-1:0] TO_ONE =
    {{(TO_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  logic                 ext_s1, ext_s2, ext_s3;
  logic                 ext_edge;
  logic                 ext_mode;
  logic                 defer, defer_nxt;
  logic [31:0]          timer, reload;
  logic [ID_WIDTH-1:0]  next_id;
  logic [CNT_WIDTH-1:0] trig_cnt_inc;
  logic                 raw_req, req, last;
  logic                 issue, skip, start_run;

  // Periods 0 and 1 behave as 2, so the reload value is never below 1.
  assign reload = (CONF_PERIOD < 32'd2) ? 32'd1
                                        : CONF_PERIOD - 32'd1;

  assign raw_req = ext_mode ? ext_edge : (timer == 32'd0);

  // A request colliding with a TRIG cycle is replayed one cycle later.
  assign req = (raw_req && !TRIG) || defer;

  assign trig_cnt_inc = (&TRIG_CNT) ? TRIG_CNT : TRIG_CNT + CNT_ONE;
  assign last = (CONF_N_TRIG != '0) && (trig_cnt_inc == CONF_N_TRIG);

  assign BUSY = (state != IDLE);

  always_comb begin
    state_nxt = state;
    defer_nxt = 1'b0;
    issue     = 1'b0;
    skip      = 1'b0;
    start_run = 1'b0;
    unique case (state)
      IDLE: begin
        if (START && !STOP) begin
          state_nxt = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (STOP) begin
          state_nxt = IDLE;
        end else begin
          defer_nxt = raw_req && TRIG;
          if (req) begin
            if (READY)          issue     = 1'b1;
            else if (CONF_SKIP) skip      = 1'b1;
            else                state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (STOP) begin
          state_nxt = IDLE;
        end else begin
          skip = req;
          if (READY) begin
            issue     = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue && last) begin
      state_nxt = IDLE;
      defer_nxt = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state       <= IDLE;
      ext_s1      <= 1'b0;
      ext_s2      <= 1'b0;
      ext_s3      <= 1'b0;
      ext_edge    <= 1'b0;
      ext_mode    <= 1'b0;
      defer       <= 1'b0;
      timer       <= 32'd0;
      next_id     <= '0;
      TRIG        <= 1'b0;
      TRIG_ID     <= '0;
      DONE        <= 1'b0;
      TRIG_CNT    <= '0;
      SKIP_CNT    <= '0;
      TIMEOUT_CNT <= '0;
    end else begin
      state    <= state_nxt;
      defer    <= defer_nxt;
      ext_s1   <= EXT_TRIG;
      ext_s2   <= ext_s1;
      ext_s3   <= ext_s2;
      ext_edge <= ext_s2 && !ext_s3;
      TRIG     <= issue;
      DONE     <= issue && last;
      if (start_run) begin
        timer       <= reload;
        ext_mode    <= CONF_EXT;
        TRIG_CNT    <= '0;
        SKIP_CNT    <= '0;
        TIMEOUT_CNT <= '0;
      end else begin
        if (state != IDLE) begin
          timer <= (timer == 32'd0) ? reload : timer - 32'd1;
        end
        if (issue) begin
          TRIG_ID  <= next_id;
          next_id  <= next_id + ID_ONE;
          TRIG_CNT <= trig_cnt_inc;
        end
        if (skip && !(&SKIP_CNT)) begin
          SKIP_CNT <= SKIP_CNT + CNT_ONE;
        end
        if (TIME_OUT && state != IDLE && !(&TIMEOUT_CNT)) begin
          TIMEOUT_CNT <= TIMEOUT_CNT + TO_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tlu_trig_seq.sv
// tb_tlu_trig_seq: scoreboard bench for tlu_trig_seq with a
// behavioural reference model and directed plus random runs.
module tb_tlu_trig_seq;

  localparam int IDW = 4;
  localparam int CW  = 32;
  localparam int TW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          conf_ext = 1'b0;
  logic          conf_skip = 1'b0;
  logic [31:0]   conf_period = 32'd10;
  logic [CW-1:0] conf_n = '0;
  logic          ext = 1'b0;
  logic          ready = 1'b1;
  logic          to = 1'b0;

  logic           trig, busy, done;
  logic [IDW-1:0] trig_id;
  logic [CW-1:0]  trig_cnt, skip_cnt;
  logic [TW-1:0]  to_cnt;

  tlu_trig_seq #(
    .ID_WIDTH(IDW), .CNT_WIDTH(CW), .TO_CNT_WIDTH(TW)
  ) dut (
    .SYS_CLK(clk), .SYS_RST(rst),
    .START(start), .STOP(stop),
    .CONF_EXT(conf_ext), .CONF_SKIP(conf_skip),
    .CONF_PERIOD(conf_period), .CONF_N_TRIG(conf_n),
    .EXT_TRIG(ext), .READY(ready), .TIME_OUT(to),
    .TRIG(trig), .TRIG_ID(trig_id), .BUSY(busy), .DONE(done),
    .TRIG_CNT(trig_cnt), .SKIP_CNT(skip_cnt),
    .TIMEOUT_CNT(to_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int prints = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (prints < 60) begin
        prints++;
        $display("FAIL %s: got %0h expected %0h at t=%0t",
                 name, act, exp, $time);
      end
    end
  endtask

  typedef struct {
    int             cyc;
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
    bit             done;
  } exp_t;

  exp_t sb[$];

  // Reference model: requests derived arithmetically from the start
  // cycle (internal) or from a history of sampled EXT_TRIG values.
  int             cyc = 0;
  bit             m_run, m_pend, m_defer, m_trig, m_ext;
  int             m_s, m_pe;
  logic [IDW-1:0] m_id, m_lastid;
  logic [CW-1:0]  m_cnt, m_skip;
  logic [TW-1:0]  m_to;
  bit             eh[$];
  bit             raw, eff, iss, fin;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_defer = 0; m_trig = 0; m_ext = 0;
    m_s = 0; m_pe = 2;
    m_id = '0; m_lastid = '0;
    m_cnt = '0; m_skip = '0; m_to = '0;
    eh = '{0, 0, 0, 0, 0};
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      eh.push_back(ext);
      void'(eh.pop_front());
      raw = 0; iss = 0; fin = 0;
      if (m_run) begin
        if (m_ext) raw = eh[1] && !eh[0];
        else       raw = ((cyc - m_s) % m_pe) == 0;
      end
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_pend = 0; m_defer = 0;
          m_s = cyc;
          m_pe = (conf_period < 2) ? 2 : int'(conf_period);
          m_ext = conf_ext;
          m_cnt = '0; m_skip = '0; m_to = '0;
        end
      end else begin
        if (to && m_to != '1) m_to = m_to + 1'b1;
        if (stop) begin
          m_run = 0; m_pend = 0; m_defer = 0;
        end else begin
          eff = (raw && !m_trig) || m_defer;
          m_defer = raw && m_trig;
          if (m_pend) begin
            if (eff && m_skip != '1) m_skip = m_skip + 1'b1;
            if (ready) iss = 1;
          end else if (eff) begin
            if (ready) iss = 1;
            else if (conf_skip) begin
              if (m_skip != '1) m_skip = m_skip + 1'b1;
            end else m_pend = 1;
          end
          if (iss) begin
            m_pend = 0;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            fin = (conf_n != 0) && (m_cnt == conf_n);
            sb.push_back('{cyc, m_id, m_cnt, fin});
            m_lastid = m_id;
            m_id = m_id + 1'b1;
            if (fin) begin
              m_run = 0; m_defer = 0;
            end
          end
        end
      end
      m_trig = iss;
    end
  end

  int   n_trig = 0;
  int   n_done = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      if (trig) n_trig++;
      if (done) n_done++;
      if (trig) begin
        if (sb.size() == 0) begin
          chk("unexpected_trig", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("trig_cycle", 64'(cyc), 64'(e.cyc));
          chk("trig_id_at_trig", 64'(trig_id), 64'(e.id));
          chk("trig_cnt_at_trig", 64'(trig_cnt), 64'(e.cnt));
          chk("done_with_trig", 64'(done), 64'(e.done));
        end
      end else begin
        chk("done_without_trig", 64'(done), 64'd0);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missing_trig", 64'd0, 64'd1);
        void'(sb.pop_front());
      end
      chk("busy", 64'(busy), 64'(m_run));
      chk("trig_cnt", 64'(trig_cnt), 64'(m_cnt));
      chk("skip_cnt", 64'(skip_cnt), 64'(m_skip));
      chk("timeout_cnt", 64'(to_cnt), 64'(m_to));
      chk("trig_id", 64'(trig_id), 64'(m_lastid));
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int t0, d0, lat;

  initial begin
    cyc_n(2);
    rst = 1'b0;
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_trig_id", 64'(trig_id), 64'd0);
    chk("rst_trig_cnt", 64'(trig_cnt), 64'd0);

    // internal, finite run of three
    conf_period = 10; conf_n = 3; ready = 1; conf_skip = 0;
    t0 = n_trig; d0 = n_done;
    pulse_start();
    cyc_n(35);
    chk("s1_trigs", 64'(n_trig - t0), 64'd3);
    chk("s1_done", 64'(n_done - d0), 64'd1);
    chk("s1_trig_cnt", 64'(trig_cnt), 64'd3);
    chk("s1_last_id", 64'(trig_id), 64'd2);
    chk("s1_busy", 64'(busy), 64'd0);

    // skip mode, READY low over the second request
    do_reset();
    conf_skip = 1; conf_n = 0;
    pulse_start();
    cyc_n(15);
    ready = 0;
    cyc_n(10);
    ready = 1;
    cyc_n(10);
    pulse_stop();
    chk("s2_skip", 64'(skip_cnt), 64'd1);
    chk("s2_trig_cnt", 64'(trig_cnt), 64'd2);
    chk("s2_last_id", 64'(trig_id), 64'd1);
    chk("s2_busy", 64'(busy), 64'd0);

    // hold mode, READY low for 25 cycles
    conf_skip = 0;
    t0 = n_trig;
    pulse_start();
    cyc_n(5);
    ready = 0;
    cyc_n(25);
    chk("s3_pend_busy", 64'(busy), 64'd1);
    chk("s3_skip", 64'(skip_cnt), 64'd2);
    chk("s3_no_trig", 64'(n_trig - t0), 64'd0);
    ready = 1;
    cyc_n(1);
    chk("s3_trig_after_ready", 64'(trig), 64'd1);
    chk("s3_id", 64'(trig_id), 64'd2);
    cyc_n(15);
    pulse_stop();
    chk("s3_trig_cnt", 64'(trig_cnt), 64'd2);

    // bring next id to 15, then external run across the wrap
    conf_period = 2; conf_n = 11;
    pulse_start();
    cyc_n(30);
    chk("s4_pre_id", 64'(trig_id), 64'd14);
    chk("s4_pre_cnt", 64'(trig_cnt), 64'd11);
    conf_ext = 1; conf_n = 0;
    pulse_start();
    cyc_n(3);
    for (int p = 0; p < 3; p++) begin
      #($urandom_range(1, 4));
      ext = 1'b1;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (trig && lat == 0) lat = k;
        if (k == 3) begin
          #($urandom_range(1, 4));
          ext = 1'b0;
        end
      end
      chk("s4_ext_latency", 64'(lat), 64'd4);
      chk("s4_ext_id", 64'(trig_id), (p == 0) ? 64'd15 : 64'(p - 1));
      cyc_n(14);
    end
    pulse_stop();
    conf_ext = 0;

    // STOP from PEND with three timeouts, then a fresh run
    conf_period = 5; conf_n = 0; conf_skip = 0; ready = 0;
    t0 = n_trig; d0 = n_done;
    pulse_start();
    cyc_n(7);
    repeat (3) begin
      to = 1; @(negedge clk);
      to = 0; @(negedge clk);
    end
    pulse_stop();
    chk("s5_timeouts", 64'(to_cnt), 64'd3);
    chk("s5_idle", 64'(busy), 64'd0);
    to = 1; @(negedge clk); to = 0;
    cyc_n(10);
    chk("s5_idle_to_ignored", 64'(to_cnt), 64'd3);
    chk("s5_no_trig", 64'(n_trig - t0), 64'd0);
    chk("s5_no_done", 64'(n_done - d0), 64'd0);
    ready = 1;
    pulse_start();
    chk("s5_to_clear", 64'(to_cnt), 64'd0);
    chk("s5_skip_clear", 64'(skip_cnt), 64'd0);
    chk("s5_busy", 64'(busy), 64'd1);
    cyc_n(5);
    chk("s5_restart_trig", 64'(trig), 64'd1);
    chk("s5_restart_id", 64'(trig_id), 64'd2);
    pulse_stop();

    // random runs against the model
    for (int r = 0; r < 40; r++) begin
      conf_ext = 1'($urandom_range(0, 1));
      conf_skip = 1'($urandom_range(0, 1));
      conf_period = $urandom_range(0, 7);
      conf_n = CW'($urandom_range(0, 6));
      ready = 1;
      pulse_start();
      for (int c = 0; c < 70; c++) begin
        ready = $urandom_range(0, 3) != 0;
        to = $urandom_range(0, 9) == 0;
        start = $urandom_range(0, 29) == 0;
        stop = $urandom_range(0, 89) == 0;
        if ($urandom_range(0, 3) == 0) begin
          #2 ext = ~ext;
        end
        @(negedge clk);
      end
      start = 0; to = 0;
      pulse_stop();
      ready = 1;
    end
    conf_ext = 0; ext = 0;

    // asynchronous reset in the middle of a run
    conf_period = 3; conf_n = 0; conf_skip = 0; ready = 1;
    pulse_start();
    cyc_n(10);
    chk("s7_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("s7_trig", 64'(trig), 64'd0);
    chk("s7_busy", 64'(busy), 64'd0);
    chk("s7_id", 64'(trig_id), 64'd0);
    chk("s7_trig_cnt", 64'(trig_cnt), 64'd0);
    chk("s7_skip", 64'(skip_cnt), 64'd0);
    chk("s7_to", 64'(to_cnt), 64'd0);
    chk("s7_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc_n(3);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
